// File: rtl/ori_video_pkg.sv
// Orion-128 video timing constants and fetch-address layout, shared by the
// timing generator, the pixel shifter and the RAM arbiter.
package ori_video_pkg;

  localparam int CLK_DIV  = 4;
  localparam int H_TOTAL  = 80;
  localparam int H_ACT    = 48;
  localparam int HS_START = 56;
  localparam int HS_LEN   = 6;
  localparam int V_TOTAL  = 312;
  localparam int V_ACT    = 256;
  localparam int VS_START = 270;
  localparam int VS_LEN   = 4;

  // Column-major Orion layout: screen base, byte column, scan line
  typedef struct packed {
    logic [1:0] base;
    logic [5:0] col;
    logic [7:0] line;
  } vaddr_t;

  // Port FA value 0 selects the top 16 KiB bank (C000), 3 selects 0000
  function automatic logic [1:0] scr_base(input logic [1:0] scr);
    return ~scr;
  endfunction

endpackage

// File: rtl/ori_vtiming_if.sv
// Timing/fetch bundle between ori_vtiming and its consumers (ori_pixel, arbiter).
interface ori_vtiming_if;
  import ori_video_pkg::*;

  logic [1:0] scr_sel_i;
  logic       cke_10m_o;
  logic       cke_pix_o;
  logic       acc_cpu_o;
  vaddr_t     vaddr_o;
  logic       hsync_n_o;
  logic       vsync_n_o;
  logic       de_o;
  logic       frame_o;

  modport master (
    input  scr_sel_i,
    output cke_10m_o, cke_pix_o, acc_cpu_o, vaddr_o,
           hsync_n_o, vsync_n_o, de_o, frame_o
  );

  modport slave (
    output scr_sel_i,
    input  cke_10m_o, cke_pix_o, acc_cpu_o, vaddr_o,
           hsync_n_o, vsync_n_o, de_o, frame_o
  );

endinterface

// File: rtl/ori_modcnt.sv
// Modulo-N counter with enable and wrap carry; exposes its next value so the
// parent can decode registered outputs one cycle ahead.
module ori_modcnt #(
  parameter int N = 2,
  parameter int W = $clog2(N)
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_nxt_o,
  output logic         wrap_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    wrap_o = en_i && (cnt_q == W'(N - 1));
    cnt_d  = cnt_q;
    if (en_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
    end
  end

  assign cnt_nxt_o = cnt_d;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ori_vtiming.sv
// Orion-128 video timing and fetch-address generator: dot/byte strobes, CPU vs
// video RAM window, column-major fetch address, syncs and display enable.
module ori_vtiming
  import ori_video_pkg::*;
#(
  parameter int CLK_DIV  = ori_video_pkg::CLK_DIV,
  parameter int H_TOTAL  = ori_video_pkg::H_TOTAL,
  parameter int H_ACT    = ori_video_pkg::H_ACT,
  parameter int HS_START = ori_video_pkg::HS_START,
  parameter int HS_LEN   = ori_video_pkg::HS_LEN,
  parameter int V_TOTAL  = ori_video_pkg::V_TOTAL,
  parameter int V_ACT    = ori_video_pkg::V_ACT,
  parameter int VS_START = ori_video_pkg::VS_START,
  parameter int VS_LEN   = ori_video_pkg::VS_LEN
) (
  input  logic          clk_i,
  input  logic          por_n_i,
  ori_vtiming_if.master vif
);

  localparam int P    = 8 * CLK_DIV;
  localparam int CD_W = $clog2(CLK_DIV);
  localparam int PH_W = $clog2(P);
  localparam int H_W  = ($clog2(H_TOTAL) > 6) ? $clog2(H_TOTAL) : 6;
  localparam int V_W  = ($clog2(V_TOTAL) > 8) ? $clog2(V_TOTAL) : 8;

  logic [PH_W-1:0] ph_n;
  logic [H_W-1:0]  h_n;
  logic [V_W-1:0]  v_n;
  logic            ph_wrap, h_wrap, v_wrap;

  ori_modcnt #(.N(P), .W(PH_W)) u_ph (
    .clk_i(clk_i), .rst_n_i(por_n_i), .en_i(1'b1),
    .cnt_nxt_o(ph_n), .wrap_o(ph_wrap)
  );

  ori_modcnt #(.N(H_TOTAL), .W(H_W)) u_h (
    .clk_i(clk_i), .rst_n_i(por_n_i), .en_i(ph_wrap),
    .cnt_nxt_o(h_n), .wrap_o(h_wrap)
  );

  ori_modcnt #(.N(V_TOTAL), .W(V_W)) u_v (
    .clk_i(clk_i), .rst_n_i(por_n_i), .en_i(h_wrap),
    .cnt_nxt_o(v_n), .wrap_o(v_wrap)
  );

  logic   scr_q, scr_unused;
  logic [1:0] scr_sel_q, scr_sel_d;
  logic   cke_10m_q, cke_10m_d, cke_pix_q, cke_pix_d, acc_cpu_q, acc_cpu_d;
  logic   hsync_n_q, hsync_n_d, vsync_n_q, vsync_n_d, de_q, de_d, frame_q, frame_d;
  logic   act_n;
  vaddr_t vaddr_q, vaddr_d;

  assign scr_q      = 1'b0;
  assign scr_unused = scr_q;

  // Decode from the next counter state so each registered output lines up
  // with the counter values of the cycle it is presented in.
  always_comb begin
    act_n     = (h_n < H_W'(H_ACT)) && (v_n < V_W'(V_ACT));
    scr_sel_d = v_wrap ? vif.scr_sel_i : scr_sel_q;
    cke_10m_d = &ph_n[CD_W-1:0];
    cke_pix_d = act_n && (ph_n == PH_W'(P - 1));
    acc_cpu_d = !(act_n && (ph_n >= PH_W'(2 * CLK_DIV)) && (ph_n <= PH_W'(4 * CLK_DIV - 1)));
    de_d      = (h_n >= H_W'(1)) && (h_n <= H_W'(H_ACT)) && (v_n < V_W'(V_ACT));
    hsync_n_d = !((h_n >= H_W'(HS_START)) && (h_n < H_W'(HS_START + HS_LEN)));
    vsync_n_d = !((v_n >= V_W'(VS_START)) && (v_n < V_W'(VS_START + VS_LEN)));
    frame_d   = (v_n == V_W'(VS_START)) && (h_n == '0) && (ph_n == '0);
    vaddr_d   = vaddr_q;
    if (ph_n == '0) begin
      vaddr_d.base = scr_base(scr_sel_d);
      vaddr_d.col  = (h_n < H_W'(H_ACT)) ? h_n[5:0] : 6'd0;
      vaddr_d.line = v_n[7:0];
    end
  end

  always_ff @(posedge clk_i or negedge por_n_i) begin
    if (!por_n_i) begin
      scr_sel_q <= 2'b00;
      cke_10m_q <= 1'b0;
      cke_pix_q <= 1'b0;
      acc_cpu_q <= 1'b1;
      hsync_n_q <= 1'b1;
      vsync_n_q <= 1'b1;
      de_q      <= 1'b0;
      frame_q   <= 1'b0;
      vaddr_q   <= '{base: scr_base(2'b00), col: 6'd0, line: 8'd0};
    end else begin
      scr_sel_q <= scr_sel_d;
      cke_10m_q <= cke_10m_d;
      cke_pix_q <= cke_pix_d;
      acc_cpu_q <= acc_cpu_d;
      hsync_n_q <= hsync_n_d;
      vsync_n_q <= vsync_n_d;
      de_q      <= de_d;
      frame_q   <= frame_d;
      vaddr_q   <= vaddr_d;
    end
  end

  assign vif.cke_10m_o = cke_10m_q;
  assign vif.cke_pix_o = cke_pix_q;
  assign vif.acc_cpu_o = acc_cpu_q;
  assign vif.vaddr_o   = vaddr_q;
  assign vif.hsync_n_o = hsync_n_q;
  assign vif.vsync_n_o = vsync_n_q;
  assign vif.de_o      = de_q;
  assign vif.frame_o   = frame_q;

endmodule

// File: tb/tb_ori_vtiming.sv
// Directed bench for ori_vtiming: default-timing instance for the first line,
// a shrunken-frame instance (CLK_DIV=2, 16x50) for frame-level behaviour.
module tb_ori_vtiming;

  logic clk     = 1'b0;
  logic d_rst_n = 1'b0;
  logic s_rst_n = 1'b0;
  int   cyc     = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  ori_vtiming_if d_if ();
  ori_vtiming_if s_if ();

  ori_vtiming u_def (
    .clk_i  (clk),
    .por_n_i(d_rst_n),
    .vif    (d_if)
  );

  // Small frame: P=16, line=256 clk, frame=50 lines=12800 clk, active 8x40,
  // fetch slot ph 4..7, hsync h 10..11, vsync lines 43..45.
  ori_vtiming #(
    .CLK_DIV(2), .H_TOTAL(16), .H_ACT(8), .HS_START(10), .HS_LEN(2),
    .V_TOTAL(50), .V_ACT(40), .VS_START(43), .VS_LEN(3)
  ) u_small (
    .clk_i  (clk),
    .por_n_i(s_rst_n),
    .vif    (s_if)
  );

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic restart_small();
    s_rst_n = 1'b0;
    step();
    s_rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    d_if.scr_sel_i = 2'b01;
    s_if.scr_sel_i = 2'b00;
    d_rst_n = 1'b0;
    s_rst_n = 1'b0;
    repeat (3) step();
    n_checks++; if (d_if.cke_10m_o !== 1'b0) $display("[TB] FAIL rst_cke_10m: got %b expected 0", d_if.cke_10m_o); else n_pass++;
    n_checks++; if (d_if.cke_pix_o !== 1'b0) $display("[TB] FAIL rst_cke_pix: got %b expected 0", d_if.cke_pix_o); else n_pass++;
    n_checks++; if (d_if.acc_cpu_o !== 1'b1) $display("[TB] FAIL rst_acc_cpu: got %b expected 1", d_if.acc_cpu_o); else n_pass++;
    n_checks++; if (d_if.hsync_n_o !== 1'b1) $display("[TB] FAIL rst_hsync_n: got %b expected 1", d_if.hsync_n_o); else n_pass++;
    n_checks++; if (d_if.vsync_n_o !== 1'b1) $display("[TB] FAIL rst_vsync_n: got %b expected 1", d_if.vsync_n_o); else n_pass++;
    n_checks++; if (d_if.de_o !== 1'b0) $display("[TB] FAIL rst_de: got %b expected 0", d_if.de_o); else n_pass++;
    n_checks++; if (d_if.frame_o !== 1'b0) $display("[TB] FAIL rst_frame: got %b expected 0", d_if.frame_o); else n_pass++;
    n_checks++; if (d_if.vaddr_o !== 16'hC000) $display("[TB] FAIL rst_vaddr: got %h expected c000", d_if.vaddr_o); else n_pass++;
    d_if.scr_sel_i = 2'b00;
  endtask

  task automatic test_first_line();
    int first_cke = -1, n_cke = 0, bad_cke = 0, pix_no_cke = 0;
    int first_acc = -1, last_acc0 = -1, n_acc = 0;
    int first_pix = -1, n_pix = 0;
    int first_de = -1, last_de = -1, n_de = 0;
    int first_hs = -1, last_hs = -1, n_hs = 0;
    int bad_col = 0, bad_stable = 0;
    logic [15:0] va0, va_last, va_prev;
    d_rst_n = 1'b1;
    cyc = 0;
    va0 = d_if.vaddr_o;
    va_prev = d_if.vaddr_o;
    va_last = 16'h0;
    while (cyc < 2560) begin
      if (d_if.cke_10m_o) begin
        if (first_cke < 0) first_cke = cyc;
        n_cke++;
        if (cyc % 4 != 3) bad_cke++;
      end
      if (!d_if.acc_cpu_o) begin
        if (first_acc < 0) first_acc = cyc;
        if (cyc < 32) last_acc0 = cyc;
        n_acc++;
      end
      if (d_if.cke_pix_o) begin
        if (first_pix < 0) first_pix = cyc;
        n_pix++;
        if (!d_if.cke_10m_o) pix_no_cke++;
      end
      if (d_if.de_o) begin
        if (first_de < 0) first_de = cyc;
        last_de = cyc;
        n_de++;
      end
      if (!d_if.hsync_n_o) begin
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
        n_hs++;
      end
      if (cyc % 32 == 16 && cyc < 48 * 32 && d_if.vaddr_o[13:8] != 6'(cyc / 32)) bad_col++;
      if (cyc % 32 != 0 && d_if.vaddr_o != va_prev) bad_stable++;
      va_prev = d_if.vaddr_o;
      if (cyc == 2559) va_last = d_if.vaddr_o;
      step();
    end
    n_checks++; if (first_cke !== 3) $display("[TB] FAIL first_cke_10m: got %0d expected 3", first_cke); else n_pass++;
    n_checks++; if (n_cke !== 640 || bad_cke !== 0) $display("[TB] FAIL cke_10m_cadence: got %0d pulses %0d off-phase expected 640 and 0", n_cke, bad_cke); else n_pass++;
    n_checks++; if (first_acc !== 8 || last_acc0 !== 15) $display("[TB] FAIL first_slot: got %0d..%0d expected 8..15", first_acc, last_acc0); else n_pass++;
    n_checks++; if (n_acc !== 384) $display("[TB] FAIL line_slot_cycles: got %0d expected 384", n_acc); else n_pass++;
    n_checks++; if (first_pix !== 31) $display("[TB] FAIL first_cke_pix: got %0d expected 31", first_pix); else n_pass++;
    n_checks++; if (n_pix !== 48 || pix_no_cke !== 0) $display("[TB] FAIL cke_pix_count: got %0d (%0d w/o cke_10m) expected 48 (0)", n_pix, pix_no_cke); else n_pass++;
    n_checks++; if (first_de !== 32 || last_de !== 1567 || n_de !== 1536) $display("[TB] FAIL de_window: got %0d..%0d n=%0d expected 32..1567 n=1536", first_de, last_de, n_de); else n_pass++;
    n_checks++; if (first_hs !== 1792 || last_hs !== 1983 || n_hs !== 192) $display("[TB] FAIL hsync_window: got %0d..%0d n=%0d expected 1792..1983 n=192", first_hs, last_hs, n_hs); else n_pass++;
    n_checks++; if (bad_col !== 0) $display("[TB] FAIL vaddr_col_step: got %0d bad slots expected 0", bad_col); else n_pass++;
    n_checks++; if (bad_stable !== 0) $display("[TB] FAIL vaddr_stable: got %0d mid-period changes expected 0", bad_stable); else n_pass++;
    n_checks++; if (va0 !== 16'hC000) $display("[TB] FAIL vaddr_cycle0: got %h expected c000", va0); else n_pass++;
    n_checks++; if (va_last !== 16'hC000) $display("[TB] FAIL vaddr_cycle2559: got %h expected c000", va_last); else n_pass++;
    n_checks++; if (d_if.vaddr_o !== 16'hC001) $display("[TB] FAIL vaddr_line1: got %h expected c001", d_if.vaddr_o); else n_pass++;
    d_rst_n = 1'b0;
  endtask

  task automatic test_frame();
    int n_acc = 0, late_acc = 0, n_pix = 0, late_pix = 0;
    int first_vs = -1, last_vs = -1, n_vs = 0, n_frame = 0, frame_at = -1;
    logic [15:0] va_end;
    va_end = 16'h0;
    s_if.scr_sel_i = 2'b00;
    restart_small();
    while (cyc < 12800) begin
      if (!s_if.acc_cpu_o) begin n_acc++; if (cyc >= 10240) late_acc++; end
      if (s_if.cke_pix_o) begin n_pix++; if (cyc >= 10240) late_pix++; end
      if (!s_if.vsync_n_o) begin
        if (first_vs < 0) first_vs = cyc;
        last_vs = cyc;
        n_vs++;
      end
      if (s_if.frame_o) begin n_frame++; frame_at = cyc; end
      if (cyc == 12799) va_end = s_if.vaddr_o;
      step();
    end
    n_checks++; if (n_acc !== 1280) $display("[TB] FAIL frame_slot_cycles: got %0d expected 1280", n_acc); else n_pass++;
    n_checks++; if (late_acc !== 0 || late_pix !== 0) $display("[TB] FAIL blank_lines_quiet: got acc=%0d pix=%0d expected 0 0", late_acc, late_pix); else n_pass++;
    n_checks++; if (n_pix !== 320) $display("[TB] FAIL frame_cke_pix: got %0d expected 320", n_pix); else n_pass++;
    n_checks++; if (first_vs !== 11008 || last_vs !== 11775 || n_vs !== 768) $display("[TB] FAIL vsync_window: got %0d..%0d n=%0d expected 11008..11775 n=768", first_vs, last_vs, n_vs); else n_pass++;
    n_checks++; if (n_frame !== 1 || frame_at !== 11008) $display("[TB] FAIL frame_pulse: got n=%0d at %0d expected n=1 at 11008", n_frame, frame_at); else n_pass++;
    n_checks++; if (va_end !== 16'hC031) $display("[TB] FAIL vaddr_last_line: got %h expected c031", va_end); else n_pass++;
    n_checks++; if (s_if.vaddr_o !== 16'hC000) $display("[TB] FAIL vaddr_frame_wrap: got %h expected c000", s_if.vaddr_o); else n_pass++;
  endtask

  task automatic test_line37();
    int n_slot = 0, bad_line = 0, bad_col = 0, n_acc = 0;
    restart_small();
    while (cyc < 9728) begin
      if (cyc >= 9472) begin
        if (!s_if.acc_cpu_o) n_acc++;
        if (cyc % 16 == 8 && cyc - 9472 < 128) begin
          n_slot++;
          if (s_if.vaddr_o[7:0] != 8'h25) bad_line++;
          if (s_if.vaddr_o[13:8] != 6'((cyc - 9472) / 16)) bad_col++;
        end
      end
      step();
    end
    n_checks++; if (n_slot !== 8 || bad_line !== 0) $display("[TB] FAIL line37_addr: got %0d slots %0d bad expected 8 slots 0 bad", n_slot, bad_line); else n_pass++;
    n_checks++; if (bad_col !== 0) $display("[TB] FAIL line37_col: got %0d bad expected 0", bad_col); else n_pass++;
    n_checks++; if (n_acc !== 32) $display("[TB] FAIL line37_slots: got %0d expected 32", n_acc); else n_pass++;
  endtask

  task automatic test_screen_select();
    int bad_base = 0;
    s_if.scr_sel_i = 2'b00;
    restart_small();
    while (cyc < 12800) begin
      if (cyc == 2560) s_if.scr_sel_i = 2'b01;
      if (s_if.vaddr_o[15:14] != 2'b11) bad_base++;
      step();
    end
    n_checks++; if (bad_base !== 0) $display("[TB] FAIL scr_no_tear: got %0d early switches expected 0", bad_base); else n_pass++;
    n_checks++; if (s_if.vaddr_o !== 16'h8000) $display("[TB] FAIL scr_frame2: got %h expected 8000", s_if.vaddr_o); else n_pass++;
    while (cyc < 13056) begin
      if (cyc == 12900) s_if.scr_sel_i = 2'b10;
      step();
    end
    n_checks++; if (s_if.vaddr_o !== 16'h8001) $display("[TB] FAIL scr_frame2_line1: got %h expected 8001", s_if.vaddr_o); else n_pass++;
    s_if.scr_sel_i = 2'b00;
  endtask

  task automatic test_reset_midframe();
    int first_cke = -1, first_acc = -1;
    logic de15;
    de15 = 1'b1;
    s_if.scr_sel_i = 2'b10;
    restart_small();
    while (cyc < 7765) step();
    n_checks++; if (s_if.acc_cpu_o !== 1'b0 || s_if.vaddr_o !== 16'hC51E) $display("[TB] FAIL pre_reset_state: got acc=%b vaddr=%h expected 0 c51e", s_if.acc_cpu_o, s_if.vaddr_o); else n_pass++;
    #1 s_rst_n = 1'b0;
    #1;
    n_checks++; if (s_if.acc_cpu_o !== 1'b1 || s_if.vaddr_o !== 16'hC000 || s_if.de_o !== 1'b0 || s_if.cke_10m_o !== 1'b0) $display("[TB] FAIL async_reset: got acc=%b vaddr=%h de=%b cke=%b expected 1 c000 0 0", s_if.acc_cpu_o, s_if.vaddr_o, s_if.de_o, s_if.cke_10m_o); else n_pass++;
    step();
    step();
    s_rst_n = 1'b1;
    cyc = 0;
    while (cyc < 16) begin
      if (s_if.cke_10m_o && first_cke < 0) first_cke = cyc;
      if (!s_if.acc_cpu_o && first_acc < 0) first_acc = cyc;
      if (cyc == 15) de15 = s_if.de_o;
      step();
    end
    n_checks++; if (first_cke !== 1 || first_acc !== 4) $display("[TB] FAIL restart_phase: got cke@%0d acc@%0d expected 1 and 4", first_cke, first_acc); else n_pass++;
    n_checks++; if (s_if.vaddr_o !== 16'hC100 || de15 !== 1'b0 || s_if.de_o !== 1'b1) $display("[TB] FAIL restart_origin: got vaddr=%h de15=%b de16=%b expected c100 0 1", s_if.vaddr_o, de15, s_if.de_o); else n_pass++;
    s_if.scr_sel_i = 2'b00;
  endtask

  initial begin
    test_reset();
    test_first_line();
    test_frame();
    test_line37();
    test_screen_select();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
